uart_tx_fifo: RTL
=================

Name: uart_tx_fifo

Overview:
Transmit-side byte buffer placed directly upstream of uart_transceiver. Accepts bytes from the host logic in single-cycle writes, stores up to DEPTH of them, and launches them one at a time into the transceiver through its tx_start/tx_data/tx_busy/tx_done handshake. The host can then burst several bytes without waiting a full UART frame (about 10 x 5208 clocks at 50 MHz / 9600 baud) per byte.

Parameters:
DEPTH, 16, number of byte entries; must be a power of two, 2 or more
AW, 4, pointer width; must equal log2(DEPTH)

Ports:
clk  input  1  system clock, 50 MHz nominal
rstn  input  1  asynchronous active-low reset
wr_en  input  1  host write strobe, one byte per cycle
wr_data  input  8  host byte
clr_ovf  input  1  clears the sticky overflow flag
full  output  1  count == DEPTH
empty  output  1  count == 0
count  output  AW+1  bytes currently stored, excluding the byte in flight
overflow  output  1  sticky; a write was dropped
tx_start  output  1  single-cycle launch pulse to uart_transceiver
tx_data  output  8  byte to transmit, held stable while in flight
tx_busy  input  1  from uart_transceiver
tx_done  input  1  from uart_transceiver, single-cycle end-of-frame pulse

Behaviour:
- Reset (async assert, sync-released internal use): wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, overflow=0, tx_start=0, tx_data=8'h00, state=IDLE. Storage array contents are don't-care.
- Storage: circular buffer with AW-bit pointers that wrap DEPTH-1 -> 0. count is a separate AW+1-bit register. full and empty are decoded from count and are registered-consistent with it.
- Write: accepted at a clk edge if wr_en=1 and (full=0 or a pop happens at the same edge). An accepted write stores wr_data at wr_ptr and increments wr_ptr.
- Dropped write: wr_en=1, full=1, no pop at the same edge. Storage, wr_ptr and count are unchanged; overflow is set to 1.
- overflow stays 1 until clr_ovf=1. If clr_ovf and a new drop occur at the same edge, set wins.
- count update: +1 on write only, -1 on pop only, unchanged on simultaneous write and pop.
- Launch FSM states: IDLE, START, WAIT.
  - IDLE: if empty=0 and tx_busy=0 at an edge, pop. tx_data <= mem[rd_ptr], rd_ptr++, tx_start <= 1, go to START.
  - START: tx_start is high for exactly this one cycle. At the next edge tx_start <= 0 and go to WAIT.
  - WAIT: hold tx_data. On the edge where tx_done=1, go to IDLE. The next launch can occur at the following edge, giving a 1-cycle gap after tx_done.
  - tx_done seen in IDLE or START is ignored.
- Latency: a write at edge k into an empty FIFO with an idle transmitter pops at edge k+1. tx_start is then high from edge k+1 to edge k+2, and count returns to 0 after edge k+1.
- Write into an empty FIFO at the same edge an IDLE pop would be evaluated: no pop, because empty was 1. Pop happens at the next edge. There is no bypass path.
- Ordering: bytes are transmitted strictly in write order across pointer wrap-around.
- Reset mid-frame: all state clears immediately and tx_start drops asynchronously. The in-flight byte and all stored bytes are lost. The transceiver is reset by the same rstn.
- tx_busy=1 while in IDLE (for example, another master using the transmitter) blocks launch indefinitely; the FIFO keeps accepting writes.

Test Plan:
- Reset: pulse rstn low for 10 cycles mid-run -> empty=1, full=0, count=0, overflow=0, tx_start=0, tx_data=00 while rstn low and afterwards.
- Single byte: write 8'hA5 into an idle system -> tx_start high for exactly 1 cycle, 1 cycle after the write; tx_data=A5 held until tx_done; tx line shows an 0xA5 frame; empty=1 afterwards.
- Burst: write 55, AA, 00, FF on 4 consecutive cycles -> count peaks at 3, because the first byte pops immediately; the transmitter emits 55, AA, 00, FF in order; each tx_start follows the previous tx_done by 2 cycles.
- Fill/overflow (DEPTH=16, transmitter busy): write 18 bytes 00..11 -> bytes 00 in flight, 01..10 stored, count=16, full=1. Byte 11 is dropped and overflow=1. clr_ovf clears overflow. Drained output is 00..10.
- Write at full with simultaneous pop: with full=1, write 8'h3C on the cycle of a launch -> accepted, count stays 16, overflow stays 0, 3C is sent last.
- Wrap-around: 40 bytes written in bursts of 10, each burst sent after the previous drains -> all 40 received in order, pointers wrap twice, no overflow.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Transmit byte FIFO feeding uart_transceiver: buffers host writes and launches
// them one at a time through the tx_start/tx_busy/tx_done handshake.
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          clr_ovf,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic          tx_start,
    output logic [7:0]    tx_data,
    input  logic          tx_busy,
    input  logic          tx_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0]   ONE_C   = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [7:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          full_r;
    logic          empty_r;
    logic          overflow_r;
    logic          tx_start_r;
    logic [7:0]    tx_data_r;
    state_t        state_r;

    state_t        state_nxt_s;
    logic          pop_s;
    logic          wr_acc_s;
    logic          drop_s;
    logic [AW:0]   count_nxt_s;
    logic          ovf_nxt_s;

    // Launch FSM next-state and pop decision
    always_comb begin
        state_nxt_s = state_r;
        pop_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (!empty_r && !tx_busy) begin
                    pop_s       = 1'b1;
                    state_nxt_s = START;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            START: state_nxt_s = WAIT;
            WAIT: begin
                if (tx_done) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Write acceptance, occupancy and sticky overflow; a pop frees a slot at a full edge
    always_comb begin
        wr_acc_s    = wr_en && (!full_r || pop_s);
        drop_s      = wr_en && full_r && !pop_s;
        count_nxt_s = count_r;
        ovf_nxt_s   = overflow_r;
        case ({wr_acc_s, pop_s})
            2'b10:   count_nxt_s = count_r + ONE_C;
            2'b01:   count_nxt_s = count_r - ONE_C;
            default: count_nxt_s = count_r;
        endcase
        if (drop_s) begin
            ovf_nxt_s = 1'b1;
        end else if (clr_ovf) begin
            ovf_nxt_s = 1'b0;
        end else begin
            ovf_nxt_s = overflow_r;
        end
    end

    // Byte storage; contents need no reset
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers, flags, FSM state and launch outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= {(AW+1){1'b0}};
            full_r     <= 1'b0;
            empty_r    <= 1'b1;
            overflow_r <= 1'b0;
            tx_start_r <= 1'b0;
            tx_data_r  <= 8'h00;
            state_r    <= IDLE;
        end else begin
            state_r    <= state_nxt_s;
            tx_start_r <= pop_s;
            if (pop_s) begin
                tx_data_r <= mem_r[rd_ptr_r];
                rd_ptr_r  <= rd_ptr_r + PTR_ONE;
            end
            if (wr_acc_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            count_r    <= count_nxt_s;
            full_r     <= (count_nxt_s == DEPTH_C);
            empty_r    <= (count_nxt_s == {(AW+1){1'b0}});
            overflow_r <= ovf_nxt_s;
        end
    end

    assign full     = full_r;
    assign empty    = empty_r;
    assign count    = count_r;
    assign overflow = overflow_r;
    assign tx_start = tx_start_r;
    assign tx_data  = tx_data_r;

endmodule
